multi_port_bypass_unit: RTL

Parametrised operand-forwarding and hazard unit for the BRISC-V in-order pipelines. Generalises the five-stage bypass control to P read ports and S forwarding stages. Adds a registered scoreboard for long-latency writers (loads, multiply/divide), a WAW issue stall and a stall watchdog. Sits beside decode: selects each operand's source and raises the decode stall.

---
 rtl/bypass_pkg.sv | 28 ++
 rtl/bypass_scoreboard.sv | 50 +++++
 rtl/multi_port_bypass_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bypass_pkg.sv
// rtl/bypass_pkg.sv - shared constants, helpers and types for the multi-port bypass unit
`ifndef BYPASS_REG_ADDR_W
`define BYPASS_REG_ADDR_W 5
`endif

package bypass_pkg;

  // Select code meaning "take the operand from the register file"
  localparam int SEL_REGFILE = 0;

  typedef logic [`BYPASS_REG_ADDR_W-1:0] reg_addr_t;

  // Ceiling log2 with a floor of 1 so a single-stage select is still one bit wide
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Stage k forwards on select code k+1; code 0 is reserved for the register file
  function automatic int stage_to_sel(input int stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/bypass_scoreboard.sv
// rtl/bypass_scoreboard.sv - pending-write scoreboard for long-latency writers
module bypass_scoreboard
  import bypass_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int REG_ADDR_W     = 5,
  localparam int NUM_REGS      = 2 ** REG_ADDR_W
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 set_en,
  input  logic [REG_ADDR_W-1:0]                set_rd,
  input  logic                                 clr_en,
  input  logic [REG_ADDR_W-1:0]                clr_rd,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rd_addr,
  input  logic [REG_ADDR_W-1:0]                issue_addr,
  output logic [NUM_READ_PORTS-1:0]            rd_pending,
  output logic                                 issue_pending,
  output logic [NUM_REGS-1:0]                  pending_mask
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Next pending mask: clear first so a same-cycle set on the same register wins
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_rd] = 1'b0;
    if (set_en) pending_d[set_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Pending flops; reset drops every outstanding writer at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Registered lookups: a completion this cycle is still seen as pending
  always_comb begin
    rd_pending = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_pending[p] = pending_q[rd_addr[p*REG_ADDR_W +: REG_ADDR_W]];
    end
    issue_pending = pending_q[issue_addr];
  end

  assign pending_mask = pending_q;

endmodule

// File: rtl/multi_port_bypass_unit.sv
// rtl/multi_port_bypass_unit.sv - operand forwarding selects and decode stall; BYPASS_PERF_CNT_EN adds perf counters
module multi_port_bypass_unit
  import bypass_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_FWD_STAGES  = 3,
  parameter int REG_ADDR_W      = 5,
  parameter int STALL_TIMEOUT   = 255,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000,
  localparam int SELW           = clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rs_addr,
  input  logic [NUM_READ_PORTS-1:0]            rs_used,
  input  logic [NUM_FWD_STAGES-1:0]            stage_wen,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stage_rd,
  input  logic [NUM_FWD_STAGES-1:0]            stage_ready,
  input  logic                                 issue_valid,
  input  logic                                 issue_wen,
  input  logic [REG_ADDR_W-1:0]                issue_rd,
  input  logic                                 issue_long,
  input  logic                                 complete_valid,
  input  logic [REG_ADDR_W-1:0]                complete_rd,
  output logic [NUM_READ_PORTS*SELW-1:0]       rs_bypass_sel,
  output logic                                 stall,
  output logic                                 stall_timeout,
  input  logic                                 scan
`ifdef BYPASS_PERF_CNT_EN
  ,
  output logic [31:0]                          perf_stall_cycles,
  output logic [31:0]                          perf_bypass_events
`endif
);

  localparam int P        = NUM_READ_PORTS;
  localparam int S        = NUM_FWD_STAGES;
  localparam int W        = REG_ADDR_W;
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int WD_W     = (clog2(STALL_TIMEOUT + 1) > 8) ? clog2(STALL_TIMEOUT + 1) : 8;

  logic [P-1:0]      port_hit;
  logic [P-1:0]      port_hazard;
  logic [P-1:0]      port_sb_stall;
  logic [P-1:0]      rd_pending;
  logic              issue_pending;
  logic              waw_stall;
  logic              stall_c;
  logic              sb_set;
  logic [P*SELW-1:0] raw_sel;
  logic [NUM_REGS-1:0] pending_mask;

  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       cycle_q, cycle_d;

  assign sb_set = issue_valid & issue_wen & issue_long & ~stall_c & (issue_rd != '0);

  bypass_scoreboard #(
    .NUM_READ_PORTS (P),
    .REG_ADDR_W     (W)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .set_en        (sb_set),
    .set_rd        (issue_rd),
    .clr_en        (complete_valid),
    .clr_rd        (complete_rd),
    .rd_addr       (rs_addr),
    .issue_addr    (issue_rd),
    .rd_pending    (rd_pending),
    .issue_pending (issue_pending),
    .pending_mask  (pending_mask)
  );

  // Per-port priority match: the lowest matching stage holds the youngest value
  always_comb begin
    logic [W-1:0]    addr;
    logic            hit;
    logic            hit_ready;
    logic [SELW-1:0] hit_sel;
    port_hit      = '0;
    port_hazard   = '0;
    port_sb_stall = '0;
    raw_sel       = '0;
    for (int p = 0; p < P; p++) begin
      addr      = rs_addr[p*W +: W];
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_sel   = SELW'(SEL_REGFILE);
      if (rs_used[p] && (addr != '0)) begin
        for (int k = 0; k < S; k++) begin
          if (!hit && stage_wen[k] && (stage_rd[k*W +: W] == addr)) begin
            hit       = 1'b1;
            hit_ready = stage_ready[k];
            hit_sel   = SELW'(stage_to_sel(k));
          end
        end
      end
      port_hit[p]      = hit;
      port_hazard[p]   = hit & ~hit_ready;
      port_sb_stall[p] = rs_used[p] & ~hit & rd_pending[p];
      if (hit && hit_ready) raw_sel[p*SELW +: SELW] = hit_sel;
    end
  end

  assign waw_stall     = issue_valid & issue_wen & issue_pending;
  assign stall_c       = (|port_hazard) | (|port_sb_stall) | waw_stall;
  assign stall         = stall_c;
  assign rs_bypass_sel = stall_c ? {P{SELW'(SEL_REGFILE)}} : raw_sel;
  assign stall_timeout = timeout_q;

  // Watchdog: count consecutive stall cycles, saturate, latch the timeout flag
  always_comb begin
    wd_d      = '0;
    timeout_d = timeout_q;
    cycle_d   = cycle_q + 32'd1;
    if (stall_c) wd_d = (wd_q == {WD_W{1'b1}}) ? wd_q : wd_q + 1'b1;
    if (wd_d == WD_W'(STALL_TIMEOUT)) timeout_d = 1'b1;
  end

  // Watchdog, sticky flag and free-running cycle counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
      cycle_q   <= '0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      cycle_q   <= cycle_d;
    end
  end

`ifndef SYNTHESIS
  // Scan trace inside the configured cycle window
  always @(posedge clock) begin
    if (scan && (longint'(cycle_q) >= longint'(SCAN_CYCLES_MIN)) &&
        (longint'(cycle_q) <= longint'(SCAN_CYCLES_MAX))) begin
      $display("core%0d cyc=%0d sel=%h stall=%0b pend=%h wd=%0d hit=%b",
               CORE, cycle_q, rs_bypass_sel, stall_c, pending_mask, wd_q, port_hit);
    end
  end
`endif

`ifdef BYPASS_PERF_CNT_EN
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
  logic [31:0] perf_bypass_events_q, perf_bypass_events_d;

  // Saturating counters for stall cycles and cycles that forwarded an operand
  always_comb begin
    perf_stall_cycles_d  = perf_stall_cycles_q;
    perf_bypass_events_d = perf_bypass_events_q;
    if (stall_c && (perf_stall_cycles_q != 32'hFFFF_FFFF))
      perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
    if (!stall_c && (|raw_sel) && (perf_bypass_events_q != 32'hFFFF_FFFF))
      perf_bypass_events_d = perf_bypass_events_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles_q  <= '0;
      perf_bypass_events_q <= '0;
    end else begin
      perf_stall_cycles_q  <= perf_stall_cycles_d;
      perf_bypass_events_q <= perf_bypass_events_d;
    end
  end

  assign perf_stall_cycles  = perf_stall_cycles_q;
  assign perf_bypass_events = perf_bypass_events_q;
`endif

endmodule
